instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] zero).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port redirect  input  1  one-cycle branch/jump request; target comes from branch_a and branch_b.
REQ-005 SHALL have port branch_a  input  32  first branch operand, e.g. PC, register data or zero.
REQ-006 SHALL have port branch_b  input  32  second branch operand, e.g. imm12, jump offset or branch offset.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_addr  output  32  fetch address.
REQ-010 SHALL have port imem_rsp_valid  input  1  response data valid.
REQ-011 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-012 SHALL have port instr_valid  output  1  instruction presented to decode.
REQ-013 SHALL have port instr_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port instr  output  32  presented instruction.
REQ-015 SHALL have port instr_addr  output  32  address of presented instruction.
REQ-016 SHALL have port misalign_fault  output  1  sticky misaligned-target flag.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD, FAULT, with exactly one outstanding memory request at any time.
REQ-018 SHALL in REQ assert imem_req_valid with imem_addr = pc, hold imem_addr stable until imem_req_valid && imem_req_ready, then go to WAIT.
REQ-019 SHALL in WAIT, on imem_rsp_valid with no stale mark, register imem_rsp_data into instr and pc into instr_addr, then go to HOLD; instr_valid rises the cycle after imem_rsp_valid.
REQ-020 SHALL in HOLD assert instr_valid and keep instr and instr_addr stable until instr_valid && instr_ready, then set pc = instr_addr + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0) and go to REQ the next cycle.
REQ-021 SHALL compute target = (branch_a + branch_b) mod 2^32 with bit 0 cleared, sampled in the redirect cycle.
REQ-022 SHALL on redirect in HOLD drop the held instruction (instr_valid low next cycle), set pc = target and go to REQ; this also applies when the same cycle completes an instr handshake, and redirect wins for the next PC.
REQ-023 SHALL on redirect in REQ or WAIT set pc = target and mark the in-flight request stale; a REQ request still completes with its old address.
REQ-024 SHALL discard the stale response when it arrives and then go to REQ with the redirected pc.
REQ-025 SHALL apply the latest redirect when redirects arrive on several cycles before the stale response returns.
REQ-026 SHALL go to FAULT, set misalign_fault = 1 and issue no further requests when target bit 1 = 1.
REQ-027 SHALL hold FAULT, with imem_req_valid = 0 and instr_valid = 0, until reset.
REQ-028 SHALL ignore imem_rsp_valid outside WAIT.

Reset
REQ-029 SHALL on rst_n low asynchronously force state = REQ, pc = RESET_PC, stale mark = 0, imem_req_valid = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_addr = 0, misalign_fault = 0.
REQ-030 SHALL assert imem_req_valid in the first clk edge after rst_n deasserts.
REQ-031 SHALL abandon any outstanding request when reset hits mid-operation, and SHALL not accept a late response until a new request has been issued.

Structure
REQ-032 SHALL place the FSM state typedef, the encodings and the RESET_PC default in shared package fetch_pkg.
REQ-033 SHALL be a single module with no sub-module; operand selection is done upstream by two external branch-input muxes.

Verification
REQ-034 SHALL cover sequential fetch: reset, ready = 1, 1-cycle memory -> addresses 0x0, 0x4, 0x8 in order, instr/instr_addr match.
REQ-035 SHALL cover backpressure: instr_ready low 5 cycles in HOLD -> instr/instr_addr stable, no new imem request issued.
REQ-036 SHALL cover redirect in WAIT: branch_a = 0x100, branch_b = 0x20, memory latency 3 -> stale word dropped, next imem_addr = 0x120, first presented instr_addr = 0x120.
REQ-037 SHALL cover redirect with handshake in HOLD: a = 0x40, b = 0xFFFF_FFF9 -> target 0x38 (bit 0 cleared), next request 0x38, not instr_addr + 4.
REQ-038 SHALL cover the misaligned target: a = 0x0, b = 0x6 -> misalign_fault = 1 next cycle, imem_req_valid = 0 thereafter, cleared only by rst_n.
REQ-039 SHALL cover wrap and reset: fetch at 0xFFFF_FFFC -> next request 0x0; rst_n pulsed during WAIT -> the late response is ignored and the next request is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the default reset PC and the target helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ILEN         = 32'd4;

  function automatic logic [31:0] br_target(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a + b) & ~32'h1;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, one held instruction,
// redirect with stale-response discard, sticky misaligned-target fault.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] branch_a,
  input  logic [31:0] branch_b,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        misalign_fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  instr_q;
  logic [31:0]  iaddr_q;
  logic         stale_q;
  logic         req_valid_q;
  logic         ivalid_q;
  logic         fault_q;

  logic [31:0]  tgt;
  logic [31:0]  pc_d;
  logic [31:0]  hold_pc_d;
  logic         bad_redir;

  assign tgt       = br_target(branch_a, branch_b);
  assign pc_d      = redirect ? tgt : pc_q;
  assign hold_pc_d = redirect ? tgt : iaddr_q + ILEN;
  assign bad_redir = redirect && tgt[1] && (state_q != S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      instr_q     <= '0;
      iaddr_q     <= '0;
      stale_q     <= 1'b0;
      req_valid_q <= 1'b0;
      ivalid_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else if (bad_redir) begin
      state_q     <= S_FAULT;
      fault_q     <= 1'b1;
      req_valid_q <= 1'b0;
      ivalid_q    <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          pc_q <= pc_d;
          if (!req_valid_q) begin
            // nothing issued yet, so a redirect simply retargets
            req_valid_q <= 1'b1;
            addr_q      <= pc_d;
          end else begin
            if (redirect) stale_q <= 1'b1;
            if (imem_req_ready) begin
              req_valid_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          pc_q <= pc_d;
          if (imem_rsp_valid) begin
            if (stale_q || redirect) begin
              stale_q     <= 1'b0;
              req_valid_q <= 1'b1;
              addr_q      <= pc_d;
              state_q     <= S_REQ;
            end else begin
              instr_q  <= imem_rsp_data;
              iaddr_q  <= pc_q;
              ivalid_q <= 1'b1;
              state_q  <= S_HOLD;
            end
          end else if (redirect) begin
            stale_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || instr_ready) begin
            pc_q        <= hold_pc_d;
            addr_q      <= hold_pc_d;
            ivalid_q    <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_FAULT: begin
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = addr_q;
  assign instr_valid    = ivalid_q;
  assign instr          = instr_q;
  assign instr_addr     = iaddr_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-programmable memory model plus a
// decode-side scoreboard of expected instruction addresses.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] branch_a;
  logic [31:0] branch_b;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .branch_a       (branch_a),
    .branch_b       (branch_b),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ivalid(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) break;
      cyc();
    end
    chk(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (imem_req_valid) break;
      cyc();
    end
    chk(tag, {31'b0, imem_req_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  // memory: accepts a request, answers lat cycles after the handshake
  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat;
      end
    end
  end

  // decode side: every accepted instruction must match the queue head
  initial begin
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("instr_extra", {31'b0, instr_valid}, 32'd0);
        end else begin
          ea = exp_q.pop_front();
          chk("instr_addr", instr_addr, ea);
          chk("instr_data", instr, mem_word(ea));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0;
    branch_a = '0;
    branch_b = '0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_iaddr", instr_addr, 32'd0);
    chk("rst_fault", {31'b0, misalign_fault}, 32'd0);

    // sequential fetch
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst_n = 1'b1;
    cyc();
    chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    drain("seq_drain");
    instr_ready = 1'b0;

    // backpressure in HOLD
    wait_ivalid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_iaddr", instr_addr, 32'hC);
      chk("bp_instr", instr, mem_word(32'hC));
      chk("bp_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    lat = 3;
    exp_q.push_back(32'hC);
    instr_ready = 1'b1;
    drain("bp_drain");
    instr_ready = 1'b0;

    // redirect while waiting on a slow response
    wait_req("rw_req");
    cyc();
    chk("rw_in_wait", {31'b0, imem_req_valid}, 32'd0);
    redirect = 1'b1;
    branch_a = 32'h100;
    branch_b = 32'h20;
    cyc();
    redirect = 1'b0;
    exp_q.push_back(32'h120);
    instr_ready = 1'b1;
    wait_req("rw_req2");
    chk("rw_addr", imem_addr, 32'h120);
    lat = 1;
    drain("rw_drain");
    instr_ready = 1'b0;

    // redirect together with an instr handshake
    wait_ivalid("rh_wait");
    exp_q.push_back(32'h124);
    instr_ready = 1'b1;
    redirect = 1'b1;
    branch_a = 32'h40;
    branch_b = 32'hFFFF_FFF9;
    cyc();
    redirect = 1'b0;
    instr_ready = 1'b0;
    chk("rh_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rh_addr", imem_addr, 32'h38);
    chk("rh_drop", {31'b0, instr_valid}, 32'd0);
    exp_q.push_back(32'h38);
    instr_ready = 1'b1;
    drain("rh_drain");
    instr_ready = 1'b0;

    // address wrap
    wait_ivalid("wr_wait");
    redirect = 1'b1;
    branch_a = 32'hFFFF_FFF0;
    branch_b = 32'hC;
    cyc();
    redirect = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_drop", {31'b0, instr_valid}, 32'd0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    instr_ready = 1'b1;
    drain("wr_drain");
    instr_ready = 1'b0;

    // reset while a response is outstanding
    lat = 3;
    wait_req("mr_req");
    cyc();
    chk("mr_in_wait", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_addr", imem_addr, RST_PC);
    chk("mr_rst_iaddr", instr_addr, 32'd0);
    chk("mr_rst_req", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mr_ignore", {31'b0, instr_valid}, 32'd0);
    end
    chk("mr_req_after", {31'b0, imem_req_valid}, 32'd1);
    chk("mr_addr_after", imem_addr, RST_PC);
    lat = 1;
    imem_req_ready = 1'b1;
    exp_q.push_back(RST_PC);
    instr_ready = 1'b1;
    drain("mr_drain");
    instr_ready = 1'b0;

    // misaligned target
    wait_ivalid("mf_wait");
    redirect = 1'b1;
    branch_a = 32'h0;
    branch_b = 32'h6;
    cyc();
    chk("mf_fault", {31'b0, misalign_fault}, 32'd1);
    chk("mf_noreq", {31'b0, imem_req_valid}, 32'd0);
    chk("mf_noinstr", {31'b0, instr_valid}, 32'd0);
    branch_a = 32'h200;
    branch_b = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mf_hold_req", {31'b0, imem_req_valid}, 32'd0);
      chk("mf_sticky", {31'b0, misalign_fault}, 32'd1);
    end
    redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mf_clr", {31'b0, misalign_fault}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mf_restart", {31'b0, imem_req_valid}, 32'd1);
    chk("mf_restart_addr", imem_addr, RST_PC);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
